// File: rtl/mcu_spi_target.sv
// mcu_spi_target: SPI target (mode 0, MSB first) for the MCU link.
// The SPI pins are oversampled in the clk domain. MOSI is deframed into a
// byte stream: one frame per CSn-low period, one strobe per byte, and start
// marks the first byte of a frame. A reply byte stream is shifted out on
// MISO at the same time.
//
// Ports:
//   clk, reset_n            system clock (>= 4x SCLK), sync active-low reset
//   spi_sclk/csn/mosi       asynchronous SPI inputs from the MCU
//   spi_miso                SPI data to the MCU
//   data_out_strobe/start   received-byte pulse / first-byte-of-frame flag
//   data_out[7:0]           received byte, held until the next strobe
//   tx_data[7:0], tx_valid  reply byte offered to the MCU
//   tx_ack                  pulse: tx_data consumed
//
// Build option: define MCU_SPI_MISO_EN to include the MISO reply path.
// Without it, spi_miso and tx_ack are tied low.
module mcu_spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       data_out_strobe,
  output logic       data_out_start,
  output logic [7:0] data_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_mosi_sync;
  logic                   r_sclk_d;
  logic [SYNC_STAGES:0]   r_live;
  logic                   r_armed;
  state_t                 r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx_sr;
  logic                   r_byte_done;
  logic                   r_first;

  logic w_sclk, w_csn, w_mosi, w_sclk_rise, w_live;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_csn       = r_csn_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  // Once the reset preset values have drained out of the chains, the
  // synced pins reflect the real pin levels.
  assign w_live      = r_live[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sclk_sync     <= '0;
      r_csn_sync      <= '1;
      r_mosi_sync     <= '0;
      r_sclk_d        <= 1'b0;
      r_live          <= '0;
      r_armed         <= 1'b0;
      r_state         <= IDLE;
      r_bit_cnt       <= '0;
      r_rx_sr         <= '0;
      r_byte_done     <= 1'b0;
      r_first         <= 1'b0;
      data_out_strobe <= 1'b0;
      data_out_start  <= 1'b0;
      data_out        <= '0;
    end else begin
      r_sclk_sync     <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_csn_sync      <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
      r_mosi_sync     <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d        <= w_sclk;
      r_live          <= {r_live[SYNC_STAGES-1:0], 1'b1};
      r_byte_done     <= 1'b0;
      data_out_strobe <= 1'b0;
      data_out_start  <= 1'b0;

      if (r_byte_done) begin
        data_out        <= r_rx_sr;
        data_out_strobe <= 1'b1;
        data_out_start  <= r_first;
        r_first         <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          // A frame may only start from a genuinely observed CSn-high level,
          // so a reset in mid-frame does not resume the aborted frame.
          if (w_csn) begin
            if (w_live) r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed <= 1'b0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_first   <= 1'b1;
          r_bit_cnt <= '0;
          r_state   <= SHIFT;
        end
        SHIFT: begin
          if (w_csn) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
          end else if (w_sclk_rise) begin
            r_rx_sr   <= {r_rx_sr[6:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MCU_SPI_MISO_EN
  logic [7:0] r_tx_sr;
  logic       w_sclk_fall;

  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign spi_miso    = (r_state == SHIFT) & r_tx_sr[7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_sr <= '0;
      tx_ack  <= 1'b0;
    end else begin
      tx_ack <= 1'b0;
      if (r_state == LOAD || (r_byte_done && r_state == SHIFT && !w_csn)) begin
        r_tx_sr <= tx_valid ? tx_data : IDLE_BYTE;
        tx_ack  <= tx_valid;
      end else if (r_state == SHIFT && w_sclk_fall && r_bit_cnt != 3'd0) begin
        // The falling edge that follows a byte's 8th rise lands after the
        // reload. Shifting on it would drop the new MSB, so that edge is
        // skipped.
        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
      end
    end
  end
`else
  logic w_unused_tx;
  assign w_unused_tx = ^{tx_data, tx_valid, IDLE_BYTE};
  assign spi_miso    = 1'b0;
  assign tx_ack      = 1'b0;
`endif

endmodule
